uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of the UART receiver.
- Captures each byte presented with the receiver's one-cycle receive strobe.
- Stores bytes in a power-of-two circular buffer.
- Offers bytes to the consumer (command decoder / display logic) over a valid/ready handshake, with first-word-fall-through and a sticky overflow flag.

Parameters:
- DEPTH_LOG2, 4, log2 of buffer depth; depth = 2**DEPTH_LOG2 entries; legal range 1..8.
- DATA_W, 8, byte width; fixed to the UART character width and not overridden in practice.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  DATA_W  byte from the receiver; sampled only when rx_strobe=1.
- rx_strobe  input  1  one-cycle pulse; the byte on rx_data is complete.
- out_data  output  DATA_W  head-of-buffer byte; valid only when out_valid=1.
- out_valid  output  1  buffer is non-empty.
- out_ready  input  1  consumer accepts; a pop occurs when out_valid & out_ready.
- level  output  DATA_W+1 truncated to DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky; a byte was dropped because the buffer was full.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (on a clk edge with reset=1):
  - wr_ptr = 0, rd_ptr = 0, level = 0.
  - out_valid = 0, out_data = 0, full = 0, overflow = 0.
  - Storage contents are not cleared.
  - Reset dominates every other input in that cycle.
  - Reset mid-stream discards all stored bytes; a strobe coinciding with reset is dropped.
- Pointers: DEPTH_LOG2+1 bits, extra MSB for full/empty disambiguation.
  - Address = low DEPTH_LOG2 bits; pointers wrap naturally modulo 2**(DEPTH_LOG2+1).
  - empty = (wr_ptr == rd_ptr); full = (MSBs differ and low bits equal).
- Push: rx_strobe=1 and (not full, or pop in the same cycle).
  - mem[wr_ptr] <= rx_data; wr_ptr increments.
- Pop: out_valid & out_ready; rd_ptr increments.
- Level update: push only +1; pop only -1; push+pop unchanged; neither unchanged.
- Full plus simultaneous pop and strobe: both accepted, level stays DEPTH, no overflow.
- Empty plus strobe: out_valid may not assert the same cycle; pop is impossible while empty.
- First-word-fall-through:
  - out_data is the combinational read of mem[rd_ptr low bits]; out_valid = !empty.
  - Latency: strobe at edge N into an empty buffer gives out_valid=1 and out_data=that byte after edge N (visible during cycle N+1).
- Consumer must hold out_ready independent of out_data; out_data is stable while out_valid=1 and no pop occurs.
- Overflow: strobe while full with no pop in the same cycle drops the byte and sets overflow=1 on that edge; pointers and level are unchanged.
  - overflow_clr=1 clears overflow on the next edge.
  - Clear coinciding with a new overflow event: set wins, overflow stays 1.
- rx_strobe held high for multiple cycles is treated as multiple pushes; the upstream receiver guarantees single-cycle pulses.
- No combinational path from rx_strobe to out_valid; out_ready affects only the next-state logic.

Optional Feature:
- Macro: UART_RX_FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds parameter AF_LEVEL (default DEPTH-2) and output port almost_full (1 bit).
  - almost_full is registered: 1 when level >= AF_LEVEL after the update, reset value 0.
  - Intended for software/RTS-style flow control.
- Undefined: no AF_LEVEL parameter, no almost_full port, no related logic; all other behaviour identical.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8.
  - Byte typedef uart_byte_t.
  - Default CLK_RATE = 100000000 and BAUD_RATE = 9600 constants, shared with the receiver and transmitter.
- Sub-module uart_fifo_mem:
  - Dual-port storage array, synchronous write, asynchronous read.
  - Parameterised by DEPTH_LOG2 and DATA_W.
  - Pointer, level and flag logic stays in uart_rx_fifo.

Test Plan:
- Reset then single strobe with rx_data=0x41, out_ready=0: out_valid=1 and out_data=0x41 the cycle after the strobe; level=1.
- Strobe 0x00..0x0F (DEPTH=16) with out_ready=0: full=1, level=16; then out_ready=1 drains 0x00..0x0F in order over 16 cycles, ending with out_valid=0, level=0.
- Full buffer plus extra strobe 0xAA, no pop: overflow=1, level stays 16, 0xAA never appears. overflow_clr pulse clears it; clear and a new drop in the same cycle leave overflow=1.
- Full buffer, strobe 0x55 and out_ready=1 in the same cycle: head byte popped, 0x55 stored, level=16, overflow=0. The 0x55 emerges last after draining.
- Push 20 and pop 20 interleaved (pointer wrap, DEPTH=16): output sequence equals input sequence; level never exceeds 2.
- Reset asserted with 5 bytes stored and a coincident strobe: next cycle level=0, out_valid=0, overflow=0. With UART_RX_FIFO_ALMOST_FULL_EN, almost_full=0 after reset and 1 exactly when level reaches 14.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, transmitter and receive buffer.
package uart_pkg;

   localparam int UART_DATA_W = 8;
   localparam int CLK_RATE    = 100000000;
   localparam int BAUD_RATE   = 9600;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive buffer: synchronous write, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the pointer logic.
module uart_fifo_mem #(
   parameter int DEPTH_LOG2 = 4,
   parameter int DATA_W     = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [DATA_W-1:0]     rdata
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Write the incoming byte into the addressed slot on a push.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver.
// Captures strobed bytes into a power-of-two circular buffer and presents them
// first-word-fall-through over a valid/ready handshake, with a sticky overflow flag.
// Optional: define UART_RX_FIFO_ALMOST_FULL_EN to add the AF_LEVEL parameter and a
// registered almost_full output for RTS-style flow control.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int DATA_W     = UART_DATA_W
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   ,
   parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 2
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   rx_data,
   input  logic                rx_strobe,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DEPTH_LOG2:0] level,
   output logic                full,
   output logic                overflow,
   input  logic                overflow_clr
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   ,
   output logic                almost_full
`endif
);

   localparam int PTR_W = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W-1:0] DEPTH_VAL = PTR_W'(DEPTH);

   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  level_r;
   logic              overflow_r;

   logic [PTR_W-1:0]  wr_ptr_next_s;
   logic [PTR_W-1:0]  rd_ptr_next_s;
   logic [PTR_W-1:0]  level_next_s;
   logic              overflow_next_s;
   logic              empty_s;
   logic              full_s;
   logic              push_s;
   logic              pop_s;
   logic              drop_s;
   logic [DATA_W-1:0] head_s;

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                    (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);

   uart_fifo_mem #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (push_s),
      .waddr (wr_ptr_r[DEPTH_LOG2-1:0]),
      .wdata (rx_data),
      .raddr (rd_ptr_r[DEPTH_LOG2-1:0]),
      .rdata (head_s)
   );

   // Next-state logic: handshake decode, pointer/level update and sticky overflow.
   // A pop frees a slot in the same cycle, so a full buffer still accepts a strobe then.
   always_comb begin
      pop_s           = 1'b0;
      push_s          = 1'b0;
      drop_s          = 1'b0;
      wr_ptr_next_s   = wr_ptr_r;
      rd_ptr_next_s   = rd_ptr_r;
      level_next_s    = level_r;
      overflow_next_s = overflow_r;

      pop_s  = !empty_s && out_ready;
      push_s = rx_strobe && (!full_s || pop_s);
      drop_s = rx_strobe && full_s && !pop_s;

      if (push_s) begin
         wr_ptr_next_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_next_s = wr_ptr_r;
      end

      if (pop_s) begin
         rd_ptr_next_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_next_s = rd_ptr_r;
      end

      case ({push_s, pop_s})
         2'b10:   level_next_s = level_r + PTR_ONE;
         2'b01:   level_next_s = level_r - PTR_ONE;
         2'b11:   level_next_s = level_r;
         2'b00:   level_next_s = level_r;
         default: level_next_s = level_r;
      endcase

      // A new drop outranks a coincident clear.
      if (drop_s) begin
         overflow_next_s = 1'b1;
      end else if (overflow_clr) begin
         overflow_next_s = 1'b0;
      end else begin
         overflow_next_s = overflow_r;
      end
   end

   // State registers; reset dominates all other inputs, storage is left untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         level_r    <= {PTR_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_next_s;
         rd_ptr_r   <= rd_ptr_next_s;
         level_r    <= level_next_s;
         overflow_r <= overflow_next_s;
      end
   end

   // Head byte falls through; it reads as zero while the buffer is empty so that
   // stale storage never leaks out after reset.
   always_comb begin
      out_data = {DATA_W{1'b0}};
      if (!empty_s) begin
         out_data = head_s;
      end else begin
         out_data = {DATA_W{1'b0}};
      end
   end

   assign out_valid = !empty_s;
   assign level     = level_r;
   assign full      = (level_r == DEPTH_VAL) && full_s;
   assign overflow  = overflow_r;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   localparam logic [PTR_W-1:0] AF_VAL = PTR_W'(AF_LEVEL);

   logic almost_full_r;

   // Threshold flag computed from the post-update occupancy so it lines up with level.
   always_ff @(posedge clk) begin
      if (reset) begin
         almost_full_r <= 1'b0;
      end else begin
         almost_full_r <= (level_next_s >= AF_VAL);
      end
   end

   assign almost_full = almost_full_r;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, and a randomized phase.
// Build with UART_RX_FIFO_ALMOST_FULL_EN defined to cover the almost_full output.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int DL    = 4;
   localparam int DEPTH = 1 << DL;
   localparam int AF    = DEPTH - 2;

   logic             clk = 1'b0;
   logic             reset;
   uart_byte_t       rx_data;
   logic             rx_strobe;
   uart_byte_t       out_data;
   logic             out_valid;
   logic             out_ready;
   logic [DL:0]      level;
   logic             full;
   logic             overflow;
   logic             overflow_clr;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   logic             almost_full;
`endif

   uart_rx_fifo #(
      .DEPTH_LOG2 (DL),
      .DATA_W     (UART_DATA_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_strobe    (rx_strobe),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .level        (level),
      .full         (full),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      ,
      .almost_full  (almost_full)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of accepted bytes plus the sticky flags.
   uart_byte_t q[$];
   bit         m_ovf    = 1'b0;
   bit         m_af     = 1'b0;
   bit         check_en = 1'b0;
   bit         m_pop;
   bit         m_acc;

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_ovf    = 1'b0;
         m_af     = 1'b0;
         check_en = 1'b1;
      end else begin
         m_pop = (q.size() != 0) && out_ready;
         m_acc = rx_strobe && ((q.size() < DEPTH) || m_pop);
         if (m_pop) void'(q.pop_front());
         if (m_acc) q.push_back(rx_data);
         if (rx_strobe && !m_acc) m_ovf = 1'b1;
         else if (overflow_clr)   m_ovf = 1'b0;
         m_af = (q.size() >= AF);
      end
   end

   // Compare process: every output against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("out_data",  32'(out_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
         chk("level",     32'(level),     32'(q.size()));
         chk("full",      32'(full),      32'(q.size() == DEPTH));
         chk("overflow",  32'(overflow),  32'(m_ovf));
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
         chk("almost_full", 32'(almost_full), 32'(m_af));
`endif
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      rx_data      = 8'h00;
      rx_strobe    = 1'b0;
      out_ready    = 1'b0;
      overflow_clr = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_level", 32'(level), 32'd0);
      chk("reset_data",  32'(out_data), 32'd0);

      // Single byte falls through one cycle after its strobe.
      rx_data = 8'h41; rx_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0;
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_data",  32'(out_data), 32'h41);
      chk("t1_level", 32'(level), 32'd1);
      do_reset();

      // Fill completely with 0x00..0x0F.
      for (int i = 0; i < DEPTH; i++) begin
         rx_data = 8'(i); rx_strobe = 1'b1;
         tick();
      end
      rx_strobe = 1'b0;
      chk("t2_full",  32'(full), 32'd1);
      chk("t2_level", 32'(level), 32'd16);
      chk("t2_head",  32'(out_data), 32'h00);

      // Drop while full, clear, then clear racing a new drop.
      rx_data = 8'hAA; rx_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0;
      chk("t3_ovf_set", 32'(overflow), 32'd1);
      chk("t3_level",   32'(level), 32'd16);
      chk("t3_head",    32'(out_data), 32'h00);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      chk("t3_ovf_clr", 32'(overflow), 32'd0);
      rx_strobe = 1'b1; overflow_clr = 1'b1;
      tick();
      rx_strobe = 1'b0; overflow_clr = 1'b0;
      chk("t3_set_wins", 32'(overflow), 32'd1);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;

      // Full with simultaneous pop and strobe: both accepted.
      rx_data = 8'h55; rx_strobe = 1'b1; out_ready = 1'b1;
      tick();
      rx_strobe = 1'b0; out_ready = 1'b0;
      chk("t4_level", 32'(level), 32'd16);
      chk("t4_ovf",   32'(overflow), 32'd0);
      chk("t4_head",  32'(out_data), 32'h01);
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) tick();
      chk("t4_last_level", 32'(level), 32'd1);
      chk("t4_last_data",  32'(out_data), 32'h55);
      tick();
      out_ready = 1'b0;
      chk("t4_empty", 32'(out_valid), 32'd0);
      chk("t4_level0", 32'(level), 32'd0);

      // Interleaved push/pop across the pointer wrap.
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rx_data = 8'($urandom); rx_strobe = 1'b1;
         tick();
         rx_strobe = 1'b0;
         chk("t5_level_le2", 32'(level <= 5'd2), 32'd1);
         tick();
         chk("t5_level_le2", 32'(level <= 5'd2), 32'd1);
      end
      out_ready = 1'b0;

      // Randomized traffic: a filling phase, then a draining phase.
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 600; i++) begin
            rx_data      = 8'($urandom);
            rx_strobe    = ($urandom_range(0, 99) < 60);
            out_ready    = ($urandom_range(0, 99) < (ph == 0 ? 40 : 75));
            overflow_clr = ($urandom_range(0, 99) < 5);
            reset        = ($urandom_range(0, 299) == 0);
            tick();
         end
      end
      rx_strobe = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0; reset = 1'b0;
      do_reset();

      // Reset mid-stream with a coincident strobe.
      for (int i = 0; i < 5; i++) begin
         rx_data = 8'(8'h30 + i); rx_strobe = 1'b1;
         tick();
      end
      reset = 1'b1; rx_data = 8'hEE;
      tick();
      reset = 1'b0; rx_strobe = 1'b0;
      chk("t6_level", 32'(level), 32'd0);
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_ovf",   32'(overflow), 32'd0);
      chk("t6_full",  32'(full), 32'd0);

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      chk("af_reset", 32'(almost_full), 32'd0);
      for (int i = 1; i <= DEPTH; i++) begin
         rx_data = 8'(i); rx_strobe = 1'b1;
         tick();
         chk("af_threshold", 32'(almost_full), 32'(i >= 14));
      end
      rx_strobe = 1'b0;
      do_reset();
      chk("af_after_reset", 32'(almost_full), 32'd0);
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_uart_rx_fifo
